// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter: active-low REQ/GNT, FRAME/IRDY ownership tracking,
// turnaround enforcement and grant timeout. Define PCI_ARB_PARK_EN for bus parking.
module pci_bus_arbiter #(
    parameter int N_MASTERS   = 3,
    parameter int GNT_TIMEOUT = 16,
    parameter int IDX_W       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] REQ,
    output logic [N_MASTERS-1:0] GNT,
    input  logic                 FRAME,
    input  logic                 IRDY,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 bus_busy,
    output logic                 timeout
);

    // state      | meaning
    // IDLE       | bus free, arbitrating (or parked when enabled)
    // GRANTED    | one GNT low, waiting for the owner to assert FRAME
    // BUSY       | transaction in progress, no grants
    // TURNAROUND | one idle cycle before arbitration resumes
    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        BUSY,
        TURNAROUND
    } state_t;

    localparam int TW = $clog2(GNT_TIMEOUT);
    localparam logic [TW-1:0] TMR_LOAD = TW'(GNT_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic                   to_q, to_d;
    logic [IDX_W-1:0]       win;
    logic [IDX_W-1:0]       cand;
    logic                   any_req;
    logic                   grant_ok;

    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        win     = ptr_q;
        cand    = '0;
        any_req = 1'b0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % N_MASTERS);
            if (!REQ[cand]) begin
                win     = cand;
                any_req = 1'b1;
            end
        end
    end

`ifdef PCI_ARB_PARK_EN
    logic                 parked;
    logic [N_MASTERS-1:0] park_mask;

    assign parked    = (gnt_q != '1);
    assign park_mask = ~(N_MASTERS'(1) << idx_q);
    // A different requester first sees one all-high cycle before its grant.
    assign grant_ok  = !parked || (win == idx_q);
`else
    assign grant_ok  = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        tmr_d   = tmr_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '1;
                if (!FRAME) begin
                    state_d = BUSY;
                end else if (any_req && IRDY) begin
                    if (grant_ok) begin
                        gnt_d   = ~(N_MASTERS'(1) << win);
                        idx_d   = win;
                        ptr_d   = win;
                        tmr_d   = TMR_LOAD;
                        state_d = GRANTED;
                    end
                end
`ifdef PCI_ARB_PARK_EN
                else if (!any_req) begin
                    gnt_d = park_mask;
                end
`endif
            end
            GRANTED: begin
                if (!FRAME) begin
                    gnt_d   = '1;
                    state_d = BUSY;
                end else if (REQ[idx_q]) begin
                    gnt_d   = '1;
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    gnt_d   = '1;
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            BUSY: begin
                gnt_d = '1;
                if (FRAME && IRDY) state_d = TURNAROUND;
            end
            TURNAROUND: begin
                gnt_d   = '1;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '1;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(N_MASTERS - 1);
            tmr_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
            to_q    <= to_d;
        end
    end

    assign GNT       = gnt_q;
    assign grant_idx = idx_q;
    assign bus_busy  = (state_q == BUSY) || (state_q == TURNAROUND);
    assign timeout   = to_q;

endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
Central arbiter for the shared PCI bus between up to N_MASTERS devices (A, B and C in the current system).
- Samples the active-low REQ lines and drives the active-low GNT lines.
- Uses rotating round-robin priority.
- Watches FRAME/IRDY to track bus ownership and enforce one idle turnaround cycle between owners.
- Revokes grants that are not used within a timeout window.

Parameters:
N_MASTERS, 3, number of requesting devices (2..8)
GNT_TIMEOUT, 16, cycles a granted master may take to assert FRAME before the grant is revoked (>=2)
IDX_W, 2, width of grant_idx; must be >= clog2(N_MASTERS)

Ports:
clk  input  1  bus clock; all logic on posedge
rst  input  1  synchronous reset, active-high
REQ  input  N_MASTERS  per-device request, active low
GNT  output  N_MASTERS  per-device grant, active low, registered
FRAME  input  1  bus FRAME, active low, observe only
IRDY  input  1  bus IRDY, active low, observe only
grant_idx  output  IDX_W  index of current/last granted master
bus_busy  output  1  high while state is BUSY or TURNAROUND
timeout  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
Reset:
- On posedge with rst=1: GNT=all 1s, grant_idx=0, bus_busy=0, timeout=0.
- state=IDLE, priority pointer ptr=N_MASTERS-1, so device 0 wins first; wait timer=0.
- Reset mid-transfer drops all grants on that edge; the arbiter does not wait for FRAME.

General rules:
- All inputs are sampled on posedge clk.
- Outputs change only on posedge.
- At most one GNT bit is low at any time.
- Between two different GNT bits being low there is at least one cycle with all GNT high.

Arbitration:
- Search order is ptr+1, ptr+2, ... modulo N_MASTERS; the first index with REQ low wins.
- On a grant, ptr and grant_idx are set to the winner.

State machine:
- IDLE:
  - If any REQ is low and FRAME=1 and IRDY=1 sampled: GNT[w]=0 next edge, timer=0, go to GRANTED.
  - Otherwise GNT stays all high.
- GRANTED:
  - FRAME sampled 0 -> BUSY; GNT[w] returns high on the same edge. Granted devices latch their grant, so the grant is not held through the transfer.
  - REQ[w] sampled 1 before FRAME -> GNT high, go to IDLE, no timeout pulse.
  - timer == GNT_TIMEOUT-1 with FRAME still 1 -> GNT high, timeout=1 for one cycle, go to IDLE. ptr stays at w, so w loses priority.
  - Otherwise timer increments.
  - FRAME low and REQ[w] high on the same cycle: FRAME wins, go to BUSY.
- BUSY:
  - Stay while FRAME=0 or IRDY=0.
  - When both are sampled 1 -> TURNAROUND.
  - No grant is issued in BUSY, even if REQ lines are low.
- TURNAROUND:
  - One cycle, all GNT high -> IDLE.
  - Arbitration resumes in IDLE, so the earliest next GNT is 2 cycles after the bus goes idle.

Timing and boundaries:
- Request-to-grant latency from idle: REQ sampled low at edge k -> GNT low after edge k.
- A single requester holding REQ low continuously is re-granted after every TURNAROUND.
- With all N requesting, the grant order is 0,1,...,N-1,0...
- ptr wraps from N_MASTERS-1 to 0.
- FRAME already low in IDLE (a foreign or stale transaction): treated as busy; go to BUSY without any grant.

Optional Feature:
Macro: PCI_ARB_PARK_EN
- Defined (bus parking):
  - In IDLE with no REQ low, GNT[grant_idx] is held low (parked on the last master; after reset, device 0).
  - If the parked master asserts FRAME -> BUSY, GNT high.
  - If a different REQ goes low while parked: park GNT goes high for one cycle (IDLE with all high), then the normal grant.
  - If the parked master raises REQ itself: normal GRANTED with timer=0.
  - The timeout counter is not run while parked.
- Not defined: GNT is all high whenever no grant is pending; no parking logic is synthesized.

Test Plan:
Single request:
- Reset; REQ=3'b110 at cycle 2 -> GNT=3'b110 after edge 2, grant_idx=0.
- FRAME low cycles 4-7, IRDY low 5-7 -> GNT=3'b111 after edge 4, bus_busy=1 edges 4-8, then IDLE.

Round-robin:
- REQ=3'b000 held; each master runs a 2-cycle FRAME burst -> grant order 0,1,2,0.
- Never two GNT bits low at once.
- At least one all-high cycle between grants.

Timeout (GNT_TIMEOUT=16):
- REQ[1]=0, FRAME never asserted -> GNT[1] low for exactly 16 cycles, then high.
- timeout=1 for one cycle.
- Next grant goes to 2 if REQ[2]=0.

Withdrawn request:
- GNT[2] granted, REQ[2] raised 3 cycles later with FRAME=1 -> GNT high next edge, timeout stays 0.

Reset mid-BUSY:
- rst=1 while FRAME=0 -> GNT=3'b111, bus_busy=0 after that edge.
- After release, REQ=3'b000 -> device 0 is granted first.

Parking (PCI_ARB_PARK_EN):
- After device 1 finishes and no REQ is low -> GNT=3'b101 persists.
- REQ[0] goes low -> one cycle of 3'b111, then 3'b110.
